// File: rtl/inv_key_schedule.sv
// inv_key_schedule: AES-128 round keys emitted 10..0, forward expansion then on-the-fly inversion.
// Define INV_KS_LAST_KEY_IN_EN to take the round-10 key on key_in and skip the forward pass.
module inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         rk_last
);
  typedef enum logic [1:0] {IDLE, FWD, REV} state_t;
  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [31:0]  w0, w1, w2, w3, p1, p2, p3, n0, n1, n2, n3, sub_in, sw;
  logic [127:0] fwd_key, rev_key;
  logic         hs;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as x^254 (GF(2^8) inverse, 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  // one shared SubWord(RotWord()) path: fed w3 going forward, recovered previous w3 going back
  assign sub_in = (state_q == REV) ? p3 : w3;
  assign sw = {sbox(sub_in[23:16]) ^ rcon(rnd_q), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])};
  assign n0 = w0 ^ sw;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign fwd_key = {n0, n1, n2, n3};
  assign rev_key = {n0, p1, p2, p3};
  assign hs = rk_valid & rk_ready;

  always_comb begin
    state_d = state_q;
    key_d = key_q;
    rnd_d = rnd_q;
    case (state_q)
      IDLE: if (start) begin
        key_d = key_in;
`ifdef INV_KS_LAST_KEY_IN_EN
        state_d = REV;
        rnd_d = 4'd10;
`else
        state_d = FWD;
        rnd_d = 4'd1;
`endif
      end
      FWD: begin
        key_d = fwd_key;
        state_d = (rnd_q == 4'd10) ? REV : FWD;
        rnd_d = (rnd_q == 4'd10) ? rnd_q : rnd_q + 4'd1;
      end
      REV: if (hs) begin
        state_d = (rnd_q == 4'd0) ? IDLE : REV;
        key_d = (rnd_q == 4'd0) ? key_q : rev_key;
        rnd_d = (rnd_q == 4'd0) ? rnd_q : rnd_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      key_q <= '0;
      rnd_q <= '0;
    end else begin
      state_q <= state_d;
      key_q <= key_d;
      rnd_q <= rnd_d;
    end

  assign busy = state_q != IDLE;
  assign rk_valid = state_q == REV;
  assign rk_last = rk_valid && rnd_q == 4'd0;
  assign rk_idx = rnd_q;
  assign rk_data = key_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: randomized scoreboard bench against a FIPS-197 key expansion model.
module tb_inv_key_schedule;
  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready;
  logic [127:0] key_in;
  logic         busy, rk_valid, rk_last;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

`ifdef INV_KS_LAST_KEY_IN_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 11;
`endif
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct packed {logic [3:0] idx; logic [127:0] data;} exp_t;
  exp_t         sb[$];
  logic [7:0]   sbx[256];
  logic [127:0] rk[11];
  int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
  bit rdy_rand = 0, chk_busy = 0, prev_v = 0;

  inv_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box table generated by walking the multiplicative group with generator 3
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sbx[p] = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbx[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // called at a negedge; ck is always the cipher key, key_in depends on build
  task automatic do_start(input logic [127:0] ck);
    int n = 0;
    expand(ck);
    while (busy && n < 600) begin @(negedge clk); n++; end
    chk("start_idle", 128'(busy), '0);
    for (int r = 10; r >= 0; r--) sb.push_back(exp_t'{idx: 4'(r), data: rk[r]});
    start = 1'b1;
`ifdef INV_KS_LAST_KEY_IN_EN
    key_in = rk[10];
`else
    key_in = ck;
`endif
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    chk("accept_busy", 128'(busy), 128'd1);
  endtask

  task automatic wait_q_empty();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin @(posedge clk); n++; end
    chk("drain_timeout", 128'(n < 600), 128'd1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    wait_q_empty();
    chk("done_idle", 128'(busy), '0);
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    rk_ready = 1'b1;
    build_sbox();
    fork
      forever begin
        @(posedge clk);
        #1;
        rk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_v = 0;
          chk_busy = 0;
        end else begin
          if (chk_busy) begin
            chk("busy_drop", 128'(busy), '0);
            chk_busy = 0;
          end
          if (rk_valid) begin
            if (sb.size() == 0) chk("spurious_key", 128'(rk_valid), '0);
            else begin
              if (!prev_v) chk("first_latency", 128'(cyc - acc_cyc + 1), 128'(LAT));
              chk("rk_data", rk_data, sb[0].data);
              chk("rk_idx", 128'(rk_idx), 128'(sb[0].idx));
              chk("rk_last", 128'(rk_last), 128'(sb[0].idx == 4'd0));
              chk("busy_valid", 128'(busy), 128'd1);
              if (rk_ready) begin
                if (sb[0].idx == 4'd0) chk_busy = 1;
                void'(sb.pop_front());
              end
            end
          end
          prev_v = rk_valid;
        end
      end
    join_none
    #23;
    chk("rst_busy", 128'(busy), '0);
    chk("rst_valid", 128'(rk_valid), '0);
    chk("rst_last", 128'(rk_last), '0);
    chk("rst_idx", 128'(rk_idx), '0);
    chk("rst_data", rk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_release", 128'(busy), '0);
    // known-answer schedule, full throughput
    do_start(FIPS_KEY);
    chk("model_idx10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_idx1", rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    wait_done();
    // same key with random back-pressure
    rdy_rand = 1;
    do_start(FIPS_KEY);
    wait_done();
    // start pulses while busy must be ignored
    do_start(rnd_key());
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      start = 1'b1;
      key_in = rnd_key();
      @(negedge clk);
      start = 1'b0;
      chk("ignored_busy", 128'(busy), 128'd1);
    end
    wait_done();
    // back-to-back: next start on the cycle right after the idx0 handshake
    do_start(rnd_key());
    wait_q_empty();
    chk("b2b_idle", 128'(busy), '0);
    do_start(rnd_key());
    wait_done();
    for (int j = 0; j < 4; j++) begin
      do_start(rnd_key());
      wait_done();
    end
    // asynchronous reset in the middle of the reverse pass
    do_start(FIPS_KEY);
    n = 0;
    while (!(rk_valid && rk_idx == 4'd5) && n < 600) begin @(negedge clk); n++; end
    chk("reach_idx5", 128'(n < 600), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(rk_valid), '0);
    chk("async_busy", 128'(busy), '0);
    chk("async_data", rk_data, '0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("hold_valid", 128'(rk_valid), '0);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_restart", 128'(busy), '0);
    do_start('0);
    wait_done();
    rdy_rand = 0;
    do_start(rnd_key());
    wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
